// File: rtl/memmu_write_buffer_pkg.sv
// rtl/memmu_write_buffer_pkg.sv - shared MemMU write-buffer types and DEPTH-derived width helpers
package memmu_write_buffer_pkg;

  // Frame-tracking FSM: RUN while no older frame is draining, FLUSH while one is
  typedef enum logic [0:0] {
    WB_RUN   = 1'b0,
    WB_FLUSH = 1'b1
  } wb_state_e;

  // Saturating drop statistics counter geometry
  localparam int          WB_DROP_CNT_W   = 16;
  localparam logic [15:0] WB_DROP_CNT_MAX = 16'hFFFF;

  // Read/write pointer width for a power-of-two DEPTH
  function automatic int wb_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: must represent 0..DEPTH inclusive
  function automatic int wb_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/memmu_write_buffer_fifo.sv
// rtl/memmu_write_buffer_fifo.sv - circular point store with occupancy, drop detect and head presentation
module memmu_wb_fifo
  import memmu_write_buffer_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 64,
  localparam int PTR_W  = wb_ptr_w(DEPTH),
  localparam int LVL_W  = wb_level_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              pop_o,
  output logic              drop_o
);

  logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic                     full;
  logic                     valid;
  logic                     pop;
  logic                     push_acc;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign valid = (level_q != '0);
  assign pop   = valid & ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push_acc = push_i & (~full | pop);

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_acc && !pop)      level_d = level_q + 1'b1;
    else if (!push_acc && pop) level_d = level_q - 1'b1;
  end

  // Pointer and occupancy registers, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage; contents are don't-care until covered by level
  always_ff @(posedge clk_i) begin
    if (push_acc) mem_q[wr_ptr_q] <= {push_addr_i, push_data_i};
  end

  assign valid_o = valid;
  // Outputs read as zero whenever nothing is queued (including after reset)
  assign addr_o  = valid ? mem_q[rd_ptr_q][ADDR_W+DATA_W-1:DATA_W] : '0;
  assign data_o  = valid ? mem_q[rd_ptr_q][DATA_W-1:0] : '0;
  assign level_o = level_q;
  assign pop_o   = pop;
  assign drop_o  = push_i & full & ~pop;

endmodule

// File: rtl/memmu_write_buffer.sv
// rtl/memmu_write_buffer.sv - point write buffer with frame-drain tracking; optional MEMMU_WB_DROP_STATS_EN adds drop counter
module memmu_write_buffer
  import memmu_write_buffer_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 64,
  localparam int LVL_W  = wb_level_w(DEPTH)
) (
  input  logic              i_SYSTEM_clk,
  input  logic              i_SYSTEM_rst,
  input  logic              i_MemMU_P_writeValid,
  input  logic [ADDR_W-1:0] i_MemMU_P_writeAddress,
  input  logic [DATA_W-1:0] i_MemMU_P_writePayload,
  input  logic              i_SIU_newFrame,
  output logic              o_MEM_valid,
  output logic [ADDR_W-1:0] o_MEM_address,
  output logic [DATA_W-1:0] o_MEM_data,
  input  logic              i_MEM_ready,
  output logic              o_MemMU_WB_frameDone,
`ifdef MEMMU_WB_DROP_STATS_EN
  output logic [WB_DROP_CNT_W-1:0] o_MemMU_WB_dropCount,
`endif
  output logic [LVL_W-1:0]  o_MemMU_WB_level
);

  logic             pop;
  logic             drop;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] flush_start;
  wb_state_e        state_q, state_d;
  logic [LVL_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             frame_done_q, frame_done_d;

  memmu_wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i       (i_SYSTEM_clk),
    .rst_i       (i_SYSTEM_rst),
    .push_i      (i_MemMU_P_writeValid),
    .push_addr_i (i_MemMU_P_writeAddress),
    .push_data_i (i_MemMU_P_writePayload),
    .ready_i     (i_MEM_ready),
    .valid_o     (o_MEM_valid),
    .addr_o      (o_MEM_address),
    .data_o      (o_MEM_data),
    .level_o     (level),
    .pop_o       (pop),
    .drop_o      (drop)
  );

  // Entries of the closing frame: everything queued before this cycle, less what leaves now.
  // The point arriving with newFrame belongs to the new frame and is never counted.
  assign flush_start = level - LVL_W'(pop);

  // Frame tracking: count down the previous frame's entries as they drain
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    frame_done_d = 1'b0;
    if (i_SIU_newFrame) begin
      // A frame still draining is declared done when the next boundary arrives
      if (state_q == WB_FLUSH) frame_done_d = 1'b1;
      if (flush_start == '0) begin
        state_d      = WB_RUN;
        flush_cnt_d  = '0;
        frame_done_d = 1'b1;
      end else begin
        state_d     = WB_FLUSH;
        flush_cnt_d = flush_start;
      end
    end else if (state_q == WB_FLUSH && pop) begin
      flush_cnt_d = flush_cnt_q - 1'b1;
      if (flush_cnt_q == LVL_W'(1)) begin
        frame_done_d = 1'b1;
        state_d      = WB_RUN;
      end
    end
  end

  // FSM, flush counter and frameDone pulse registers
  always_ff @(posedge i_SYSTEM_clk or posedge i_SYSTEM_rst) begin
    if (i_SYSTEM_rst) begin
      state_q      <= WB_RUN;
      flush_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_MemMU_WB_frameDone = frame_done_q;
  assign o_MemMU_WB_level     = level;

`ifdef MEMMU_WB_DROP_STATS_EN
  logic [WB_DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Drop counter restarts on each frameDone pulse; a drop in that same cycle still counts
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (frame_done_q) drop_cnt_d = WB_DROP_CNT_W'(drop);
    else if (drop && drop_cnt_q != WB_DROP_CNT_MAX) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  // Saturating drop counter register
  always_ff @(posedge i_SYSTEM_clk or posedge i_SYSTEM_rst) begin
    if (i_SYSTEM_rst) drop_cnt_q <= '0;
    else              drop_cnt_q <= drop_cnt_d;
  end

  assign o_MemMU_WB_dropCount = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_memmu_write_buffer.sv
// tb/tb_memmu_write_buffer.sv - randomized self-checking bench against a queue-based frame model
module tb_memmu_write_buffer;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int LVL_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              wvalid;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              new_frame;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              frame_done;
  logic [LVL_W-1:0]  level;
`ifdef MEMMU_WB_DROP_STATS_EN
  logic [15:0]       drop_count;
`endif

  always #5 clk = ~clk;

  memmu_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_SYSTEM_clk           (clk),
    .i_SYSTEM_rst           (rst),
    .i_MemMU_P_writeValid   (wvalid),
    .i_MemMU_P_writeAddress (waddr),
    .i_MemMU_P_writePayload (wdata),
    .i_SIU_newFrame         (new_frame),
    .o_MEM_valid            (mem_valid),
    .o_MEM_address          (mem_addr),
    .o_MEM_data             (mem_data),
    .i_MEM_ready            (mem_ready),
    .o_MemMU_WB_frameDone   (frame_done),
`ifdef MEMMU_WB_DROP_STATS_EN
    .o_MemMU_WB_dropCount   (drop_count),
`endif
    .o_MemMU_WB_level       (level)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO as a queue, frame bookkeeping as "older entries still outstanding"
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;
  ent_t q[$];
  int   m_pend;
  bit   m_track;
  bit   m_fd;
  int   m_drops;
  int   pops;
  int   cyc;

  task automatic model_reset();
    q.delete();
    m_pend  = 0;
    m_track = 0;
    m_fd    = 0;
    m_drops = 0;
  endtask

  // Drive one cycle of inputs, advance the model, return at posedge+1
  task automatic cycle(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic nf, input logic rdy);
    int lvl;
    bit pop, fd, drop;
    ent_t e;
    wvalid = v; waddr = a; wdata = d; new_frame = nf; mem_ready = rdy;
    cyc++;
    lvl  = q.size();
    pop  = (lvl > 0) && rdy;
    fd   = 0;
    drop = 0;
    if (nf) begin
      if (m_track) fd = 1;
      m_pend = lvl - (pop ? 1 : 0);
      if (m_pend == 0) begin fd = 1; m_track = 0; end
      else m_track = 1;
    end else if (m_track && pop) begin
      m_pend--;
      if (m_pend == 0) begin fd = 1; m_track = 0; end
    end
    if (pop) begin
      void'(q.pop_front());
      pops++;
    end
    if (v) begin
      if (lvl < DEPTH || pop) begin
        e.a = a; e.d = d;
        q.push_back(e);
      end else drop = 1;
    end
    if (m_fd) m_drops = drop ? 1 : 0;
    else if (drop && m_drops < 16'hFFFF) m_drops++;
    m_fd = fd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wvalid = 0; waddr = '0; wdata = '0; new_frame = 0; mem_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", mem_valid); end
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", mem_data); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got=%0b exp=0", frame_done); end
`ifdef MEMMU_WB_DROP_STATS_EN
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drops got=%0d exp=0", drop_count); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single();
    cycle(1'b1, 32'h1000_0008, 64'hA5, 1'b0, 1'b1);
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", mem_valid); end
    checks++; if (mem_addr !== 32'h1000_0008) begin errors++; $display("FAIL single_addr got=%h exp=10000008", mem_addr); end
    checks++; if (mem_data !== 64'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", mem_data); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level1 got=%0d exp=1", level); end
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL single_level0 got=%0d exp=0", level); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL single_drained got=%0b exp=0", mem_valid); end
  endtask

  task automatic test_overflow();
    logic [ADDR_W-1:0] first_a;
    logic [DATA_W-1:0] first_d;
    first_a = 32'h2000_0000;
    first_d = {$urandom, $urandom};
    cycle(1'b1, first_a, first_d, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) cycle(1'b1, first_a + 32'(i * 8), {$urandom, $urandom}, 1'b0, 1'b0);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level got=%0d exp=16", level); end
    checks++; if (mem_addr !== first_a) begin errors++; $display("FAIL ovf_head_addr got=%h exp=%h", mem_addr, first_a); end
    checks++; if (mem_data !== first_d) begin errors++; $display("FAIL ovf_head_data got=%h exp=%h", mem_data, first_d); end
`ifdef MEMMU_WB_DROP_STATS_EN
    checks++; if (drop_count !== 16'd4) begin errors++; $display("FAIL ovf_drops got=%0d exp=4", drop_count); end
`endif
    // Push and pop together while full: accepted, level stays at DEPTH
    cycle(1'b1, 32'h3000_0000, {$urandom, $urandom}, 1'b0, 1'b1);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_pushpop_level got=%0d exp=16", level); end
    checks++; if (mem_addr !== q[0].a) begin errors++; $display("FAIL full_pushpop_head got=%h exp=%h", mem_addr, q[0].a); end
  endtask

  task automatic test_hold();
    logic [ADDR_W-1:0] ha;
    logic [DATA_W-1:0] hd;
    ha = q[0].a;
    hd = q[0].d;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0);
      checks++; if (mem_addr !== ha || mem_data !== hd)
        begin errors++; $display("FAIL hold_%0d got=%h/%h exp=%h/%h", i, mem_addr, mem_data, ha, hd); end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      n++;
    end
    checks++; if (level !== '0) begin errors++; $display("FAIL drain_level got=%0d exp=0", level); end
  endtask

  task automatic test_frame();
    int p0, pop6_idx, fd_idx, pulses;
    p0 = pops; pop6_idx = -1; fd_idx = -1; pulses = 0;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 32'h4000_0000 + 32'(i * 8), {$urandom, $urandom}, (i == 6), 1'b1);
      if (pops == p0 + 6 && pop6_idx < 0) pop6_idx = cyc;
      if (frame_done === 1'b1) begin pulses++; fd_idx = cyc; end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      if (frame_done === 1'b1) begin pulses++; fd_idx = cyc; end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL frame_pulses got=%0d exp=1", pulses); end
    checks++; if (fd_idx !== pop6_idx) begin errors++; $display("FAIL frame_timing got=%0d exp=%0d", fd_idx, pop6_idx); end
  endtask

  task automatic test_empty_frame();
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL empty_frame_fd got=%0b exp=1", frame_done); end
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL empty_frame_once got=%0b exp=0", frame_done); end
    // Still in RUN: a push/pop with no boundary must not produce a pulse
    cycle(1'b1, 32'h5000_0000, 64'h1, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL empty_frame_run got=%0b exp=0", frame_done); end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h6000_0000 + 32'(i * 8), {$urandom, $urandom}, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL flush_level got=%0d exp=5", level); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got=%0b exp=0", mem_valid); end
    checks++; if (level !== '0) begin errors++; $display("FAIL async_rst_level got=%0d exp=0", level); end
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL post_rst_fd_%0d got=%0b exp=0", i, frame_done); end
    end
  endtask

  task automatic test_random();
    logic v, nf, rdy;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      nf  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < 4);
      cycle(v, $urandom, {$urandom, $urandom}, nf, rdy);
      checks++; if (level !== LVL_W'(q.size())) begin errors++; $display("FAIL rnd_level c%0d got=%0d exp=%0d", i, level, q.size()); end
      checks++; if (mem_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid c%0d got=%0b", i, mem_valid); end
      if (q.size() > 0) begin
        checks++; if (mem_addr !== q[0].a || mem_data !== q[0].d)
          begin errors++; $display("FAIL rnd_head c%0d got=%h/%h exp=%h/%h", i, mem_addr, mem_data, q[0].a, q[0].d); end
      end
      checks++; if (frame_done !== m_fd) begin errors++; $display("FAIL rnd_fd c%0d got=%0b exp=%0b", i, frame_done, m_fd); end
`ifdef MEMMU_WB_DROP_STATS_EN
      checks++; if (drop_count !== 16'(m_drops)) begin errors++; $display("FAIL rnd_drops c%0d got=%0d exp=%0d", i, drop_count, m_drops); end
`endif
    end
  endtask

  initial begin
    pops = 0;
    cyc  = 0;
    test_reset();
    @(posedge clk);
    #1;
    test_single();
    test_overflow();
    test_hold();
    drain();
    test_frame();
    test_empty_frame();
    test_flush_reset();
    test_single();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
